// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine: latches a full state, transforms
// N_PAR_COLS columns per cycle, then holds the result until the consumer takes it.
module aes_mix_columns_seq #(
    parameter int NB_BYTE    = 8,
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int N_PAR_COLS = 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NB_BYTE*N_ROWS*N_COLS-1:0] i_state,
    input  logic                           i_valid,
    input  logic                           i_inverse,
    output logic                           o_ready,
    output logic [NB_BYTE*N_ROWS*N_COLS-1:0] o_state,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int ST_W      = NB_BYTE * N_ROWS * N_COLS;
    localparam int COL_W     = NB_BYTE * N_ROWS;
    localparam int SAFE_PAR  = (N_PAR_COLS < 1) ? 1 : N_PAR_COLS;
    localparam bit BAD_CONF  = (NB_BYTE != 8) || (N_ROWS != 4) || (N_PAR_COLS < 1) ||
                               ((N_COLS % SAFE_PAR) != 0);
    localparam int N_GROUPS  = BAD_CONF ? 1 : (N_COLS / SAFE_PAR);
    localparam int CNT_W     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e             fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ST_W-1:0]    blk_q, blk_d;
    logic [ST_W-1:0]    res_q, res_d;
    logic               inv_q, inv_d;
    logic               accept_s;
    logic               last_grp_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficients never exceed 0x0e, so four xtime multiples cover every product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  r [4];
        logic [3:0]  k [4];
        logic [7:0]  acc;
        logic [31:0] res;
        logic [1:0]  idx;
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        for (int i = 0; i < 4; i++) r[i] = col[31-8*i -: 8];
        res = 32'h0;
        for (int o = 0; o < 4; o++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - o);
                acc = acc ^ gmul(r[j], k[idx]);
            end
            res[31-8*o -: 8] = acc;
        end
        return res;
    endfunction

    assign accept_s   = (fsm_q == IDLE) && i_valid && !BAD_CONF;
    assign last_grp_s = (cnt_q == CNT_W'(N_GROUPS - 1));

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) fsm_q <= IDLE;
        else         fsm_q <= fsm_d;
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    fsm_d = accept_s ? BUSY : IDLE;
            BUSY:    fsm_d = last_grp_s ? DONE : BUSY;
            DONE:    fsm_d = i_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    // Output decode; a bad configuration never advertises readiness
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (fsm_q)
            IDLE:    o_ready = !BAD_CONF;
            DONE:    o_valid = 1'b1;
            default: begin
                o_ready = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    // Datapath: latch on accept, then fill the result one column group per cycle
    always_comb begin
        blk_d = blk_q;
        inv_d = inv_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (accept_s) begin
            blk_d = i_state;
            inv_d = i_inverse;
            cnt_d = '0;
        end else if (fsm_q == BUSY) begin
            for (int p = 0; p < SAFE_PAR; p++) begin
                res_d[ST_W-1-(int'(cnt_q)*SAFE_PAR+p)*COL_W -: COL_W] =
                    mix_col(blk_q[ST_W-1-(int'(cnt_q)*SAFE_PAR+p)*COL_W -: COL_W], inv_q);
            end
            cnt_d = last_grp_s ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            blk_q <= '0;
            inv_q <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            blk_q <= blk_d;
            inv_q <= inv_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign o_state = res_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench: three instances (1, 2 and 4 columns per cycle) share stimulus
// and are compared against a matrix-level GF(2^8) reference model.
module tb_aes_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] st_in;
    logic         vin, inv_in, rdy_in;
    logic [127:0] os [3];
    logic         ov [3];
    logic         ordy [3];

    int errors = 0;
    int checks = 0;
    int grp [3] = '{4, 2, 1};
    logic [127:0] res [3];
    int lat [3];

    localparam logic [127:0] V_DB  = {4{32'hdb135345}};
    localparam logic [127:0] X_DB  = {4{32'h8e4da1bc}};
    localparam logic [127:0] V_MIX = 128'hf20a225c_01010101_c6c6c6c6_d4bf5d30;
    localparam logic [127:0] X_MIX = 128'h9fdc589d_01010101_c6c6c6c6_046681e5;
    localparam logic [127:0] V_INV = 128'h8e4da1bc_9fdc589d_046681e5_01010101;
    localparam logic [127:0] X_INV = 128'hdb135345_f20a225c_d4bf5d30_01010101;

    always #5 clk = ~clk;

    aes_mix_columns_seq #(.N_PAR_COLS(1)) u_p1 (
        .i_clock(clk), .i_reset(rst), .i_state(st_in), .i_valid(vin), .i_inverse(inv_in),
        .o_ready(ordy[0]), .o_state(os[0]), .o_valid(ov[0]), .i_ready(rdy_in));
    aes_mix_columns_seq #(.N_PAR_COLS(2)) u_p2 (
        .i_clock(clk), .i_reset(rst), .i_state(st_in), .i_valid(vin), .i_inverse(inv_in),
        .o_ready(ordy[1]), .o_state(os[1]), .o_valid(ov[1]), .i_ready(rdy_in));
    aes_mix_columns_seq #(.N_PAR_COLS(4)) u_p4 (
        .i_clock(clk), .i_reset(rst), .i_state(st_in), .i_valid(vin), .i_inverse(inv_in),
        .o_ready(ordy[2]), .o_state(os[2]), .o_valid(ov[2]), .i_ready(rdy_in));

    // Reference: carry-less multiply, then polynomial reduction by 0x11B
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
        logic [7:0] fm [4][4];
        logic [7:0] im [4][4];
        logic [7:0] acc;
        logic [127:0] o;
        fm = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
               '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        im = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
               '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul_ref(inv ? im[r][j] : fm[r][j], s[127-c*32-j*8 -: 8]);
                o[127-c*32-r*8 -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on all instances, record result and latency, then release
    task automatic run_block(input logic [127:0] s, input logic inv);
        st_in = s; inv_in = inv; vin = 1'b1; rdy_in = 1'b0;
        for (int d = 0; d < 3; d++) begin lat[d] = -1; res[d] = 128'h0; end
        tick();
        vin = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            for (int d = 0; d < 3; d++)
                if (lat[d] < 0 && ov[d] === 1'b1) begin lat[d] = c; res[d] = os[d]; end
        end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_in = 128'h0; vin = 1'b0; inv_in = 1'b0; rdy_in = 1'b0;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || ordy[d] !== 1'b1 || os[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset dut%0d: valid=%b ready=%b state=%h want 0/1/0", d, ov[d], ordy[d], os[d]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        run_block(V_DB, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (res[d] !== X_DB) begin errors++; $display("FAIL fwd_db dut%0d: got %h want %h", d, res[d], X_DB); end
            checks++;
            if (lat[d] !== grp[d]) begin errors++; $display("FAIL latency dut%0d: got %0d want %0d", d, lat[d], grp[d]); end
        end
        run_block(V_MIX, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (res[d] !== X_MIX) begin errors++; $display("FAIL fwd_mix dut%0d: got %h want %h", d, res[d], X_MIX); end
        end
    endtask

    task automatic test_inverse();
        logic [127:0] r, f;
        run_block(V_INV, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (res[d] !== X_INV) begin errors++; $display("FAIL inv_vec dut%0d: got %h want %h", d, res[d], X_INV); end
        end
        for (int n = 0; n < 4; n++) begin
            r = rand128();
            f = mix_ref(r, 1'b0);
            run_block(r, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (res[d] !== f) begin errors++; $display("FAIL fwd_rand dut%0d: got %h want %h", d, res[d], f); end
            end
            run_block(f, 1'b1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (res[d] !== r) begin errors++; $display("FAIL roundtrip dut%0d: got %h want %h", d, res[d], r); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] r, e;
        logic m;
        r = rand128();
        m = 1'($urandom_range(0, 1));
        e = mix_ref(r, m);
        st_in = r; inv_in = m; vin = 1'b1; rdy_in = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            st_in = rand128(); inv_in = ~inv_in; vin = 1'b1;
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            st_in = rand128(); inv_in = ~inv_in; vin = 1'($urandom_range(0, 1));
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== 1'b1 || os[d] !== e) begin
                    errors++;
                    $display("FAIL hold dut%0d cyc%0d: valid=%b state=%h want 1/%h", d, c, ov[d], os[d], e);
                end
            end
        end
        vin = 1'b0; rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || ordy[d] !== 1'b1) begin
                errors++;
                $display("FAIL release dut%0d: valid=%b ready=%b want 0/1", d, ov[d], ordy[d]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        st_in = rand128(); inv_in = 1'b0; vin = 1'b1; rdy_in = 1'b0;
        tick();
        vin = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || ordy[d] !== 1'b1 || os[d] !== 128'h0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: valid=%b ready=%b state=%h want 0/1/0", d, ov[d], ordy[d], os[d]);
            end
        end
        tick();
        rst = 1'b0;
        run_block(V_MIX, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (res[d] !== X_MIX || lat[d] !== grp[d]) begin
                errors++;
                $display("FAIL after_reset dut%0d: got %h lat %0d want %h lat %0d", d, res[d], lat[d], X_MIX, grp[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] sq [24];
        logic         iq [24];
        logic [127:0] e;
        int p, m;
        rdy_in = 1'b1; vin = 1'b1;
        for (int k = 0; k < 24; k++) begin
            sq[k] = rand128();
            iq[k] = 1'($urandom_range(0, 1));
            st_in = sq[k]; inv_in = iq[k];
            tick();
            for (int d = 0; d < 3; d++) begin
                p = grp[d] + 2;
                m = k % p;
                checks++;
                if (ov[d] !== (m == grp[d])) begin
                    errors++;
                    $display("FAIL b2b_valid dut%0d k%0d: got %b want %b", d, k, ov[d], (m == grp[d]));
                end
                if (m == grp[d]) begin
                    e = mix_ref(sq[k-grp[d]], iq[k-grp[d]]);
                    checks++;
                    if (os[d] !== e) begin
                        errors++;
                        $display("FAIL b2b_data dut%0d k%0d: got %h want %h", d, k, os[d], e);
                    end
                end
            end
        end
        vin = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rdy_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_seq.md
AES_MIX_COLUMNS_SEQ -- requirements
Module: aes_mix_columns_seq

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8, bits per GF(2^8) element.
REQ-002 SHALL have parameter N_ROWS, default 4, bytes per column.
REQ-003 SHALL have parameter N_COLS, default 4, columns per state.
REQ-004 SHALL have parameter N_PAR_COLS, default 1, columns transformed per cycle; N_COLS mod N_PAR_COLS SHALL be 0.
REQ-005 SHALL define local BAD_CONF, true if NB_BYTE!=8, N_ROWS!=4, or N_PAR_COLS does not divide N_COLS; N_GROUPS = N_COLS/N_PAR_COLS.
REQ-006 SHALL have port i_clock, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_state, input, NB_BYTE*N_ROWS*N_COLS, input state; column 0 in MSBs; in each column row 0 in the MSB byte.
REQ-009 SHALL have port i_valid, input, 1, i_state/i_inverse qualifier.
REQ-010 SHALL have port i_inverse, input, 1: 0 = MixColumns, 1 = InvMixColumns.
REQ-011 SHALL have port o_ready, output, 1, block can accept a new state.
REQ-012 SHALL have port o_state, output, NB_BYTE*N_ROWS*N_COLS, result; same packing as i_state.
REQ-013 SHALL have port o_valid, output, 1, o_state holds a complete result.
REQ-014 SHALL have port i_ready, input, 1, downstream accepts o_state.

Function
REQ-015 Arithmetic SHALL be GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B); xtime = left shift, XOR 0x1B when the shifted-out bit is 1.
REQ-016 Forward, per column: r0'=2r0^3r1^r2^r3, r1'=r0^2r1^3r2^r3, r2'=r0^r1^2r2^3r3, r3'=3r0^r1^r2^2r3.
REQ-017 Inverse, per column: coefficient rows {0e,0b,0d,09}, rotated right by one byte per output row (r1' = 09r0^0er1^0br2^0dr3, etc.).
REQ-018 FSM states SHALL be IDLE, BUSY and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-019 IDLE with i_valid=1 SHALL be an accept: it latches i_state and i_inverse, clears the group counter and moves to BUSY. IDLE with i_valid=0 SHALL stay in IDLE.
REQ-020 BUSY SHALL, each cycle, transform group cnt (columns cnt*N_PAR_COLS .. +N_PAR_COLS-1, group 0 = MSB columns) into the result register, then increment cnt.
REQ-021 When the last group (cnt=N_GROUPS-1) is written, the FSM SHALL enter DONE on the same edge; o_valid SHALL assert exactly N_GROUPS cycles after the accept edge.
REQ-022 DONE SHALL hold o_state and o_valid stable until i_ready=1; on that edge it returns to IDLE, with o_ready=1 from the next cycle.
REQ-023 i_valid, i_state and i_inverse SHALL be ignored outside IDLE; mode is fixed per block at accept.
REQ-024 i_ready SHALL be ignored outside DONE.
REQ-025 The group counter SHALL be ceil(log2(N_GROUPS)) bits wide, minimum 1, and SHALL not wrap within a block.
REQ-026 When N_PAR_COLS=N_COLS, BUSY SHALL last exactly one cycle.
REQ-027 Throughput SHALL be one block per N_GROUPS+2 cycles when i_valid and i_ready are held high.
REQ-028 o_state SHALL be defined only while o_valid=1; between blocks it holds its last value.

Reset
REQ-029 i_reset=1 SHALL force, asynchronously: FSM to IDLE, cnt=0, o_valid=0, o_ready=1, o_state=0, latched input and mode cleared.
REQ-030 Reset asserted during BUSY or DONE SHALL discard the block with no partial o_valid.
REQ-031 After reset deassertion the block SHALL accept on the first rising edge with i_valid=1.

Verification
REQ-032 Forward, N_PAR_COLS=1: column db135345 in all 4 columns -> 8e4da1bc in all columns; o_valid 4 cycles after accept.
REQ-033 Forward, mixed columns: columns f20a225c, 01010101, c6c6c6c6, d4bf5d30 -> 9fdc589d, 01010101, c6c6c6c6, 046681e5.
REQ-034 Inverse: columns 8e4da1bc, 9fdc589d, 046681e5, 01010101 -> db135345, f20a225c, d4bf5d30, 01010101; forward-then-inverse returns random inputs unchanged.
REQ-035 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_state/o_valid stable; i_valid pulses with new data are ignored; toggling i_inverse has no effect on the result.
REQ-036 Reset mid-BUSY (after 2 groups) -> o_valid=0, o_state=0, o_ready=1 immediately; the next block completes correctly.
REQ-037 N_PAR_COLS=4 and 2: same vectors -> o_valid 1 and 2 cycles after accept respectively; back-to-back blocks every N_GROUPS+2 cycles.
